// File: rtl/return_addr_stack.sv
// Return-address stack: JAL pushes its return PC, a stop-bit return pops it,
// and top_addr gives the front end its predicted return target.
// The pointer (sp/count) can be checkpointed and restored for flush recovery;
// the storage itself is never checkpointed.
module return_addr_stack #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 8,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       pop,
  input  logic                       ckpt_save,
  input  logic                       ckpt_restore,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          top_addr,
  output logic                       top_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ckpt_sp_q, ckpt_sp_d;
  logic [CNT_W-1:0]  ckpt_count_q, ckpt_count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              is_empty, is_full;
  logic [PTR_W-1:0]  sp_top;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic              ovf_ev, unf_ev;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign sp_top   = sp_q - PTR_W'(1);

  // Next-state for pointer, count, checkpoint, error flags and the storage write
  always_comb begin
    sp_d         = sp_q;
    count_d      = count_q;
    ckpt_sp_d    = ckpt_sp_q;
    ckpt_count_d = ckpt_count_q;
    wr_en        = 1'b0;
    wr_idx       = sp_q;
    ovf_ev       = 1'b0;
    unf_ev       = 1'b0;

    if (ckpt_restore) begin
      // Restore wins over push/pop/save in the same cycle.
      sp_d    = ckpt_sp_q;
      count_d = ckpt_count_q;
    end else begin
      if (push && pop && !is_empty) begin
        // Replace the top entry; pointer and count stay put.
        wr_en  = 1'b1;
        wr_idx = sp_top;
      end else if (push) begin
        if (!is_full) begin
          wr_en   = 1'b1;
          sp_d    = sp_q + PTR_W'(1);
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_ev = 1'b1;
          if (WRAP_MODE) begin
            // Overwrite the oldest entry; count stays at DEPTH.
            wr_en = 1'b1;
            sp_d  = sp_q + PTR_W'(1);
          end
        end
      end else if (pop) begin
        if (!is_empty) begin
          sp_d    = sp_top;
          count_d = count_q - CNT_W'(1);
        end else begin
          unf_ev = 1'b1;
        end
      end

      // Snapshot reflects this cycle's push/pop.
      if (ckpt_save) begin
        ckpt_sp_d    = sp_d;
        ckpt_count_d = count_d;
      end
    end

    // Error set wins over a same-cycle clear.
    ovf_d = (ovf_q & ~err_clr) | ovf_ev;
    unf_d = (unf_q & ~err_clr) | unf_ev;

    if (reset) wr_en = 1'b0;
  end

  // Pointer, count, checkpoint and sticky flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q         <= '0;
      count_q      <= '0;
      ckpt_sp_q    <= '0;
      ckpt_count_q <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      sp_q         <= sp_d;
      count_q      <= count_d;
      ckpt_sp_q    <= ckpt_sp_d;
      ckpt_count_q <= ckpt_count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Storage array; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_addr;
  end

  assign top_addr      = is_empty ? '0 : mem_q[sp_top];
  assign top_valid     = !is_empty;
  assign empty         = is_empty;
  assign full          = is_full;
  assign count         = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: one wrapping and one saturating instance share
// the same stimulus; a reference model queues expected outputs per cycle.
module tb_return_addr_stack;

  localparam int AW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset, push, pop, ckpt_save, ckpt_restore, err_clr;
  logic [AW-1:0] push_addr;

  logic [AW-1:0] w_top, s_top;
  logic          w_tv, w_emp, w_full, w_ovf, w_unf;
  logic          s_tv, s_emp, s_full, s_ovf, s_unf;
  logic [3:0]    w_cnt, s_cnt;

  always #5 clk = ~clk;

  return_addr_stack #(.ADDR_W(AW), .DEPTH(D), .WRAP_MODE(1'b1)) dut_w (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .err_clr(err_clr),
    .top_addr(w_top), .top_valid(w_tv), .empty(w_emp), .full(w_full),
    .count(w_cnt), .overflow_err(w_ovf), .underflow_err(w_unf));

  return_addr_stack #(.ADDR_W(AW), .DEPTH(D), .WRAP_MODE(1'b0)) dut_s (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .err_clr(err_clr),
    .top_addr(s_top), .top_valid(s_tv), .empty(s_emp), .full(s_full),
    .count(s_cnt), .overflow_err(s_ovf), .underflow_err(s_unf));

  typedef struct {
    int          inst;
    logic [31:0] top;
    logic        tv, emp, full, ovf, unf;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = wrapping, 1 = saturating
  logic [31:0] m_mem [2][D];
  int          m_sp [2], m_cnt [2], m_csp [2], m_ccnt [2];
  bit          m_ovf [2], m_unf [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit p, input logic [31:0] a,
                            input bit q, input bit sv, input bit rs, input bit c);
    int  nsp, ncnt;
    bit  oe, ue;
    if (r) begin
      m_sp[i] = 0; m_cnt[i] = 0; m_csp[i] = 0; m_ccnt[i] = 0;
      m_ovf[i] = 0; m_unf[i] = 0;
      return;
    end
    nsp = m_sp[i]; ncnt = m_cnt[i]; oe = 0; ue = 0;
    if (rs) begin
      nsp = m_csp[i]; ncnt = m_ccnt[i];
    end else begin
      if (p && q && m_cnt[i] > 0) begin
        m_mem[i][(m_sp[i] + D - 1) % D] = a;
      end else if (p) begin
        if (m_cnt[i] < D) begin
          m_mem[i][m_sp[i]] = a; nsp = (m_sp[i] + 1) % D; ncnt = m_cnt[i] + 1;
        end else begin
          oe = 1;
          if (i == 0) begin
            m_mem[i][m_sp[i]] = a; nsp = (m_sp[i] + 1) % D;
          end
        end
      end else if (q) begin
        if (m_cnt[i] > 0) begin
          nsp = (m_sp[i] + D - 1) % D; ncnt = m_cnt[i] - 1;
        end else ue = 1;
      end
      if (sv) begin
        m_csp[i] = nsp; m_ccnt[i] = ncnt;
      end
    end
    m_sp[i] = nsp; m_cnt[i] = ncnt;
    m_ovf[i] = (m_ovf[i] && !c) || oe;
    m_unf[i] = (m_unf[i] && !c) || ue;
  endtask

  function automatic exp_t model_exp(input int i);
    exp_t e;
    e.inst = i;
    e.cnt  = m_cnt[i];
    e.top  = (m_cnt[i] != 0) ? m_mem[i][(m_sp[i] + D - 1) % D] : 32'h0;
    e.tv   = (m_cnt[i] != 0);
    e.emp  = (m_cnt[i] == 0);
    e.full = (m_cnt[i] == D);
    e.ovf  = m_ovf[i];
    e.unf  = m_unf[i];
    return e;
  endfunction

  task automatic compare_one(input exp_t e);
    string       p;
    logic [31:0] top;
    logic        tv, emp, fl, ov, un;
    logic [3:0]  cn;
    if (e.inst == 0) begin
      p = "wrap."; top = w_top; tv = w_tv; emp = w_emp; fl = w_full; ov = w_ovf; un = w_unf; cn = w_cnt;
    end else begin
      p = "sat.";  top = s_top; tv = s_tv; emp = s_emp; fl = s_full; ov = s_ovf; un = s_unf; cn = s_cnt;
    end
    chk({p, "top_addr"},      top,          e.top);
    chk({p, "top_valid"},     32'(tv),      32'(e.tv));
    chk({p, "empty"},         32'(emp),     32'(e.emp));
    chk({p, "full"},          32'(fl),      32'(e.full));
    chk({p, "count"},         32'(cn),      32'(e.cnt));
    chk({p, "overflow_err"},  32'(ov),      32'(e.ovf));
    chk({p, "underflow_err"}, 32'(un),      32'(e.unf));
  endtask

  // One clock of stimulus: drive, advance model, queue expectations, then compare
  task automatic cyc(input bit r, input bit p, input logic [31:0] a, input bit q,
                     input bit sv = 0, input bit rs = 0, input bit c = 0);
    reset = r; push = p; push_addr = a; pop = q;
    ckpt_save = sv; ckpt_restore = rs; err_clr = c;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, p, a, q, sv, rs, c);
      exp_q.push_back(model_exp(i));
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) compare_one(exp_q.pop_front());
    reset = 0; push = 0; pop = 0; ckpt_save = 0; ckpt_restore = 0; err_clr = 0;
  endtask

  initial begin
    reset = 1; push = 0; push_addr = '0; pop = 0;
    ckpt_save = 0; ckpt_restore = 0; err_clr = 0;
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 0; m_cnt[i] = 0; m_csp[i] = 0; m_ccnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      for (int j = 0; j < D; j++) m_mem[i][j] = '0;
    end
    #2;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset.top_valid", 32'(w_tv), 32'd0);

    // Basic push/pop
    cyc(0, 1, 32'h100, 0);
    cyc(0, 1, 32'h200, 0);
    cyc(0, 1, 32'h300, 0);
    chk("basic.top_after_push", w_top, 32'h300);
    cyc(0, 0, 0, 1);
    chk("basic.top_after_pop", w_top, 32'h200);

    // Overflow: wrap overwrites oldest, saturate drops the ninth push
    cyc(1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 1, 32'(k * 16), 0);
    chk("ovf.wrap_top", w_top, 32'h90);
    chk("ovf.sat_top",  s_top, 32'h80);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
    chk("ovf.wrap_empty", 32'(w_emp), 32'd1);

    // Underflow, push&pop when empty, error clear and set-wins-over-clear
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h55, 1);
    chk("unf.pushpop_empty_count", 32'(w_cnt), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    chk("unf.set_wins", 32'(w_unf), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Replace top with same-cycle push&pop
    cyc(1, 0, 0, 0);
    cyc(0, 1, 32'hA, 0);
    cyc(0, 1, 32'hB, 0);
    cyc(0, 1, 32'hC, 1);
    chk("replace.top", w_top, 32'hC);
    cyc(0, 0, 0, 1);
    chk("replace.next", w_top, 32'hA);

    // Checkpoint save/restore, restore ignores same-cycle push, save captures next state
    cyc(1, 0, 0, 0);
    cyc(0, 1, 32'h1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h2, 0);
    cyc(0, 1, 32'h3, 0, 0, 0);
    cyc(0, 1, 32'h4, 0, 1, 1);
    chk("ckpt.top", w_top, 32'h1);
    cyc(0, 1, 32'h7, 0, 1);
    cyc(0, 1, 32'h8, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ckpt.save_with_push", w_top, 32'h7);

    // Reset while push asserted
    cyc(1, 1, 32'hDEAD, 0);

    // Random mix
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
